// File: rtl/ser_pkg.sv
// ser_pkg -- shared definitions for the serial-to-parallel converter.
//   state_t     : FSM state encoding (IDLE = 0, SHIFT = 1)
//   count_width : bits needed to hold a bit count in the range 0..n
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// bit_counter -- frame bit counter for serial_to_parallel.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset (count -> 0)
//   clr   : synchronous clear (wins over inc)
//   inc   : increment by one, saturating at N
//   count : current count, width count_width(N)
module bit_counter
  import ser_pkg::*;
#(
  parameter int N = 4,
  parameter int W = count_width(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_COUNT = W'(N);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg < MAX_COUNT)) begin
      // Saturate so the count can never wrap back to a small value.
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/serial_to_parallel.sv
// serial_to_parallel -- assembles N serial bits into a parallel word.
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset, highest priority
//   start  : frame-start strobe (also restarts a frame in progress)
//   bit_en : serial-bit strobe; si sampled only while framing
//   si     : serial data bit
//   Q      : last completed word, held until the next frame completes
//   done   : one-cycle pulse, coincides with the Q update
//   busy   : high while a frame is being assembled
// MSB_FIRST = 1 puts the first received bit in Q[N-1], otherwise in Q[0].
module serial_to_parallel
  import ser_pkg::*;
#(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         bit_en,
  input  logic         si,
  output logic [N-1:0] Q,
  output logic         done,
  output logic         busy
);

  localparam int CW = count_width(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  state_t       state_reg, state_next;
  logic [N-1:0] shreg_reg, shreg_next;
  logic [N-1:0] q_reg, q_next;
  logic         done_reg, done_next;
  logic         cnt_clr, cnt_inc;
  logic [CW-1:0] count;
  logic [N-1:0] shifted;

  bit_counter #(.N(N), .W(CW)) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (count)
  );

  // Shift register contents after accepting si this cycle.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {shreg_reg[N-2:0], si};
    end else begin : g_lsb_first
      assign shifted = {si, shreg_reg[N-1:1]};
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    q_next     = q_reg;
    done_next  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state_reg)
      IDLE: begin
        // A lone bit_en while idle is ignored.
        if (start) begin
          state_next = SHIFT;
          shreg_next = '0;
          cnt_clr    = 1'b1;
        end
      end
      SHIFT: begin
        if (start) begin
          // Restart: drop partial bits, si of this cycle is not taken.
          shreg_next = '0;
          cnt_clr    = 1'b1;
        end else if (bit_en) begin
          shreg_next = shifted;
          cnt_inc    = 1'b1;
          if (count == LAST_BIT) begin
            q_next     = shifted;
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      q_reg     <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      q_reg     <= q_next;
      done_reg  <= done_next;
    end
  end

  assign Q    = q_reg;
  assign done = done_reg;
  assign busy = (state_reg == SHIFT);

endmodule

// File: doc/serial_to_parallel.md
SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 Parameter N, default 4, output word width in bits; legal range N >= 2.
REQ-002 Parameter MSB_FIRST, default 1, bit order: 1 = first received bit lands in Q[N-1]; 0 = first received bit lands in Q[0].
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  frame-start strobe; begins a new N-bit frame.
REQ-006 bit_en  input  1  serial-bit strobe; si is sampled only when bit_en = 1.
REQ-007 si  input  1  serial data bit.
REQ-008 Q  output  N  last completed parallel word, held until the next frame completes.
REQ-009 done  output  1  one-cycle pulse marking a Q update.
REQ-010 busy  output  1  high while a frame is being assembled.

Function
REQ-011 The FSM SHALL have exactly two states, IDLE and SHIFT.
REQ-012 IDLE: start = 1 -> SHIFT with bit count cleared to 0; a bit_en in the same cycle is ignored.
REQ-013 IDLE: bit_en = 1 with start = 0 is ignored, with no state, count or Q change.
REQ-014 SHIFT: bit_en = 1, start = 0 -> si shifted into the internal shift register (direction per MSB_FIRST); count incremented.
REQ-015 SHIFT: neither strobe -> shift register and count hold; no timeout.
REQ-016 SHIFT: start = 1 (with or without bit_en) -> frame restarts; count = 0; partial bits discarded; that cycle's si is not captured; Q is unchanged.
REQ-017 On the edge that accepts the Nth bit:
  - Q is loaded with the complete word, including that bit.
  - done = 1 for exactly the following cycle.
  - state -> IDLE.
REQ-018 Latency: Q and done SHALL be valid in the cycle immediately after the edge that samples the Nth bit_en.
REQ-019 A start asserted in the cycle in which done = 1 SHALL be accepted normally (back-to-back frames, no dead cycle).
REQ-020 busy SHALL be 1 exactly when the state is SHIFT.
REQ-021 Bit count width SHALL be clog2(N+1); the count never exceeds N and never wraps.
REQ-022 Q SHALL change only on frame completion or reset; the partial shift register is never visible on Q.

Reset
REQ-023 When reset = 1 on a rising edge:
  - state = IDLE, count = 0, shift register = 0;
  - Q = 0, done = 0, busy = 0;
  - start and bit_en in that cycle are ignored.
REQ-024 Reset mid-frame SHALL abandon the frame; no done pulse for it; Q reads 0 afterwards.
REQ-025 Reset SHALL take priority over all other inputs.

Structure
REQ-026 The state encodings (IDLE = 1'b0, SHIFT = 1'b1) SHALL live in the shared package ser_pkg, together with a clog2-based count-width function.
REQ-027 The bit count SHALL be a single sub-module bit_counter with ports clk, reset, clr, inc and count.
REQ-028 The FSM, shift register and output register SHALL be in serial_to_parallel, each with a registered state and a separate next-state block.

Verification
REQ-029 The bench SHALL cover the following directed scenarios (N = 4 unless stated):
  - MSB_FIRST = 1: start, then bit_en with si = 1,0,1,1 on consecutive cycles -> Q = 4'b1011; done high one cycle after the 4th bit; busy 1 -> 0.
  - MSB_FIRST = 0: same stimulus -> Q = 4'b1101.
  - Gaps: bits 1,1,0,0 with 3 idle cycles between strobes -> Q = 4'b1100; done only after the 4th strobe; busy stays 1 throughout the gaps.
  - Restart: start, bits 1,1, start again, bits 0,1,1,0 -> Q = 4'b0110; exactly one done pulse; Q unchanged until then.
  - Reset mid-frame: previous Q = 4'b1011, start, bits 1,0, reset for one cycle -> Q = 0, busy = 0; a following lone bit_en is ignored.
  - Back-to-back: start asserted during the done cycle, then bits 0,0,0,1 -> second done exactly 5 cycles after the first; Q = 4'b0001.
